mem_ctrl_nport: RTL and testbench
=================================

Name: mem_ctrl_nport

Overview:
- Parametrised successor to the two-client memory controller; serialises word, half and byte accesses from NCH requesters onto the 8-bit RAM/IO bus.
- Arbitration is fixed-priority or round-robin.
- Supports sign/zero extension, UART back-pressure on IO writes, and flush-abort of speculative reads.
- Sits between the ICache, LSB (and future DCache/prefetch clients) and the cpu top-level memory pins.

Parameters:
- NCH, 3, number of requester channels (>=2).
- ARB_MODE, 1, 0 = fixed priority (channel 0 highest); 1 = round-robin.
- FLUSH_MASK, 3'b011, bit i set = channel i's reads are speculative and are aborted by flush.
- IO_MASK_HI, 2'b11, value of addr[17:16] that selects IO space.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  reset; synchronous, active-high.
- rdy_in  in  1  low = freeze.
- flush  in  1  ROB clear.
- mem_din  in  8  read byte, valid the cycle after its address.
- mem_dout  out  8  write byte.
- mem_a  out  32  byte address.
- mem_wr  out  1  1 = write.
- io_buffer_full  in  1  UART tx full.
- ch_req  in  NCH  request per channel; held until ack.
- ch_we  in  NCH  1 = store.
- ch_size  in  2*NCH  per channel: 0 = byte, 1 = half, 2 = word.
- ch_unsigned  in  NCH  1 = zero-extend loads.
- ch_addr  in  32*NCH  per-channel address.
- ch_wdata  in  32*NCH  per-channel store data.
- ch_ack  out  NCH  one-cycle completion pulse.
- ch_rdata  out  32  load result, valid with ack.
- busy  out  1  high in any non-IDLE state.

Behaviour:
- Reset: state IDLE; mem_a=0, mem_dout=0, mem_wr=0, ch_ack=0, ch_rdata=0, busy=0; round-robin pointer = NCH-1 (channel 0 wins the first contest).
- States: IDLE, RD, WR, DONE.
- IDLE: picks one requesting channel and latches its fields (we, size, unsigned, addr, wdata, id). Next state is RD or WR.
  - Fixed priority: lowest index wins.
  - Round-robin: first requester after the pointer, cyclically; the pointer updates to the winner at grant.
- Length n = 1/2/4 bytes for size 0/1/2. Size 3 is treated as word. Little-endian. No alignment check.
- RD:
  - Drives mem_a = addr+k for k = 0..n-1 on consecutive cycles, mem_wr=0.
  - Captures mem_din one cycle after each address into byte k.
  - After the last capture, goes to DONE.
- WR:
  - Drives mem_a = addr+k, mem_dout = wdata[8k+7:8k], mem_wr=1 for k = 0..n-1, one byte per cycle. Then DONE.
  - IO stall: if addr[17:16]==IO_MASK_HI and io_buffer_full=1, that byte is not issued (mem_wr=0, k held) and is retried each cycle until full drops.
- DONE:
  - ch_ack[id]=1 for one cycle, ch_rdata = assembled value, sign-extended from bit 7/15 unless unsigned.
  - Store ack carries ch_rdata=0.
  - Next state IDLE. No arbitration in DONE; the requester drops req in the ack cycle.
- Latency, grant taken in cycle 0:
  - Byte read ack at cycle 3; half read ack at cycle 4; word read ack at cycle 6.
  - Word write ack at cycle 5; byte write ack at cycle 2.
  - Back-to-back: the next grant occurs in the cycle after DONE.
- Outside RD/WR: mem_wr=0, mem_a=0.
- Flush, in any cycle with rdy_in=1:
  - If the active op is a read from a FLUSH_MASK channel, it aborts: next state IDLE, no ack, no partial data kept.
  - Writes and reads from non-masked channels always complete.
  - In IDLE, masked channels are excluded from arbitration that cycle.
  - Flush in DONE of a masked read suppresses the ack.
- rdy_in low:
  - All registers hold and mem_wr is forced 0.
  - mem_a is driven with the address of the most recently issued read byte, so mem_din re-presents it.
  - On resume, capture continues correctly.
- Reset mid-operation: returns to IDLE immediately; no ack; the pointer is reset.
- Simultaneous ack and new req from the same channel: the new req is ignored until IDLE.

Test Plan:
- Word read: ch1 req, addr 0x100, bytes 0x78,0x56,0x34,0x12 -> mem_a 0x100..0x103 on cycles 1-4; ch_ack[1] at cycle 6; ch_rdata=0x12345678.
- Signed byte load: byte 0x80, unsigned=0 -> ch_rdata=0xFFFFFF80. Half 0x8001 with unsigned=1 -> 0x00008001.
- Round-robin: ch0, ch1, ch2 all requesting continuously with single-byte reads -> grants in order 0,1,2,0. With ARB_MODE=0 -> grants 0,0,0 while ch0 keeps requesting.
- IO store: byte 0x41 to 0x30000 with io_buffer_full=1 for 3 cycles -> mem_wr stays 0 for those 3 cycles; then one write with mem_dout=0x41; ack follows.
- Flush abort: flush at cycle 3 of a ch0 word read -> no ch_ack[0]; IDLE at cycle 4. Flush during a ch2 word store -> all 4 bytes are written and acked.
- rdy_in low for 2 cycles in mid word-read -> ch_rdata is still correct; ack is delayed by exactly 2 cycles; no mem_wr glitches.

Source files
------------

// File: rtl/mem_ctrl_nport.sv
// mem_ctrl_nport: arbitrates NCH requesters onto the byte-wide RAM/IO bus
module mem_ctrl_nport #(
  parameter int NCH = 3,
  parameter int ARB_MODE = 1,
  parameter logic [NCH-1:0] FLUSH_MASK = 3'b011,
  parameter logic [1:0] IO_MASK_HI = 2'b11
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              flush,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [31:0]       mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full,
  input  logic [NCH-1:0]    ch_req,
  input  logic [NCH-1:0]    ch_we,
  input  logic [2*NCH-1:0]  ch_size,
  input  logic [NCH-1:0]    ch_unsigned,
  input  logic [32*NCH-1:0] ch_addr,
  input  logic [32*NCH-1:0] ch_wdata,
  output logic [NCH-1:0]    ch_ack,
  output logic [31:0]       ch_rdata,
  output logic              busy
);
  localparam int IW = $clog2(NCH);
  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
  state_t state, state_d;
  logic [IW-1:0] id, ptr, win, c;
  logic found, we, uns, stall, abort;
  logic [1:0] sz;
  logic [2:0] k, n;
  logic [31:0] addr, wdata, data, ext;
  logic [NCH-1:0] elig;
  assign n = sz == 2'd0 ? 3'd1 : sz == 2'd1 ? 3'd2 : 3'd4;
  assign elig = ch_req & ~(flush ? FLUSH_MASK : '0);
  assign stall = addr[17:16] == IO_MASK_HI && io_buffer_full;
  assign abort = flush && !we && FLUSH_MASK[id] && (state == RD || state == DONE);
  assign ext = sz == 2'd0 ? {{24{!uns && data[7]}}, data[7:0]} :
               sz == 2'd1 ? {{16{!uns && data[15]}}, data[15:0]} : data;
  always_comb begin
    found = 1'b0;
    win = '0;
    c = '0;
    for (int i = 0; i < NCH; i++) begin
      c = ARB_MODE != 0 ? IW'((int'(ptr) + 1 + i) % NCH) : IW'(i);
      if (!found && elig[c]) begin
        found = 1'b1;
        win = c;
      end
    end
  end
  always_comb begin
    state_d = state;
    mem_a = '0;
    mem_dout = '0;
    mem_wr = 1'b0;
    ch_ack = '0;
    ch_rdata = '0;
    busy = state != IDLE;
    case (state)
      IDLE: state_d = found ? (ch_we[win] ? WR : RD) : IDLE;
      RD: begin
        mem_a = addr + 32'((k != 3'd0 && (!rdy_in || k == n)) ? k - 3'd1 : k);
        state_d = k == n ? DONE : RD;
      end
      WR: begin
        mem_a = addr + 32'(k);
        mem_dout = wdata[8*k +: 8];
        mem_wr = rdy_in && !stall;
        state_d = !stall && k == n - 3'd1 ? DONE : WR;
      end
      DONE: begin
        ch_ack[id] = rdy_in && !abort;
        ch_rdata = we ? '0 : ext;
        state_d = IDLE;
      end
    endcase
    if (abort) state_d = IDLE;
    if (!rdy_in) state_d = state;
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
      ptr <= IW'(NCH - 1);
      id <= '0;
      we <= 1'b0;
      uns <= 1'b0;
      sz <= '0;
      k <= '0;
      addr <= '0;
      wdata <= '0;
      data <= '0;
    end else if (rdy_in) begin
      state <= state_d;
      if (state == IDLE && found) begin
        id <= win;
        ptr <= ARB_MODE != 0 ? win : ptr;
        we <= ch_we[win];
        uns <= ch_unsigned[win];
        sz <= ch_size[2*win +: 2];
        addr <= ch_addr[32*win +: 32];
        wdata <= ch_wdata[32*win +: 32];
        data <= '0;
        k <= '0;
      end
      if (state == RD) begin
        k <= k + 3'd1;
        if (k != 3'd0) data[8*(k-3'd1) +: 8] <= mem_din;
      end
      if (state == WR && !stall) k <= k + 3'd1;
    end
  end
endmodule

// File: tb/tb_mem_ctrl_nport.sv
// tb_mem_ctrl_nport: directed checks of mem_ctrl_nport against a byte RAM model
module tb_mem_ctrl_nport;
  logic clk_in = 1'b0, rst_in = 1'b1, rdy_in = 1'b1, flush = 1'b0, io_buffer_full = 1'b0;
  logic [7:0] mem_din = '0, mem_dout, mem_dout_f;
  logic [31:0] mem_a, mem_a_f, ch_rdata, ch_rdata_f;
  logic mem_wr, mem_wr_f, busy, busy_f;
  logic [2:0] ch_req = '0, ch_we = '0, ch_unsigned = '0, ch_ack, ch_ack_f;
  logic [5:0] ch_size = '0;
  logic [95:0] ch_addr = '0, ch_wdata = '0;
  logic [7:0] ram [0:1023];
  logic [31:0] a_log [0:1023];
  logic [7:0] d_log [0:1023];
  logic wr_log [0:1023];
  logic [31:0] a_s, rd_s, rd;
  logic [7:0] d_s;
  logic [2:0] ack_s, fack_s;
  logic w_s, b_s, keep = 1'b0;
  int cyc = 0, sc = 0, t0 = 0, checks = 0, errors = 0, lat, nack;
  int rr_ids [0:3];
  int fp_ids [0:2];
  int nr, nf;

  always #5 clk_in = ~clk_in;

  mem_ctrl_nport dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full),
    .ch_req(ch_req), .ch_we(ch_we), .ch_size(ch_size), .ch_unsigned(ch_unsigned),
    .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_ack(ch_ack), .ch_rdata(ch_rdata), .busy(busy)
  );

  mem_ctrl_nport #(.ARB_MODE(0)) dut_fp (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush), .mem_din(mem_din),
    .mem_dout(mem_dout_f), .mem_a(mem_a_f), .mem_wr(mem_wr_f), .io_buffer_full(io_buffer_full),
    .ch_req(ch_req), .ch_we(ch_we), .ch_size(ch_size), .ch_unsigned(ch_unsigned),
    .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_ack(ch_ack_f), .ch_rdata(ch_rdata_f), .busy(busy_f)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    #4;
    sc = cyc;
    a_s = mem_a;
    w_s = mem_wr;
    d_s = mem_dout;
    ack_s = ch_ack;
    fack_s = ch_ack_f;
    rd_s = ch_rdata;
    b_s = busy;
    if (sc < 1024) begin
      a_log[sc] = a_s;
      wr_log[sc] = w_s;
      d_log[sc] = d_s;
    end
    @(posedge clk_in);
    #1;
    if (w_s) ram[a_s[9:0]] = d_s;
    mem_din = ram[a_s[9:0]];
    if (!keep) ch_req = ch_req & ~ack_s;
    cyc++;
  endtask

  task automatic start(input int ch, input logic w, input logic [1:0] s, input logic u,
                       input logic [31:0] a, input logic [31:0] wd);
    ch_we[ch] = w;
    ch_size[2*ch +: 2] = s;
    ch_unsigned[ch] = u;
    ch_addr[32*ch +: 32] = a;
    ch_wdata[32*ch +: 32] = wd;
    ch_req[ch] = 1'b1;
    t0 = cyc;
  endtask

  task automatic wait_ack(input int ch, output int l, output logic [31:0] r);
    l = -1;
    r = '0;
    for (int i = 0; i < 30; i++) begin
      tick;
      if (ack_s[ch]) begin
        l = sc - t0;
        r = rd_s;
        break;
      end
    end
  endtask

  function automatic int nwr(input int lo, input int hi);
    int s = 0;
    for (int i = lo; i <= hi; i++) s += int'(wr_log[i]);
    return s;
  endfunction

  function automatic int oh(input logic [2:0] v);
    return v[0] ? 0 : v[1] ? 1 : v[2] ? 2 : -1;
  endfunction

  task automatic do_reset;
    rst_in = 1'b1;
    tick;
    tick;
    rst_in = 1'b0;
    tick;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 8'(i * 7);
    ram[10'h100] = 8'h78; ram[10'h101] = 8'h56; ram[10'h102] = 8'h34; ram[10'h103] = 8'h12;
    ram[10'h110] = 8'h80;
    ram[10'h120] = 8'h01; ram[10'h121] = 8'h80;
    do_reset;
    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_mem_wr", 32'(mem_wr), 32'h0);
    chk("rst_mem_dout", 32'(mem_dout), 32'h0);
    chk("rst_ack", 32'(ch_ack), 32'h0);
    chk("rst_rdata", ch_rdata, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);

    start(1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
    wait_ack(1, lat, rd);
    chk("wrd_lat", 32'(lat), 32'd6);
    chk("wrd_data", rd, 32'h12345678);
    chk("wrd_ackvec", 32'(ack_s), 32'h2);
    for (int k = 0; k < 4; k++) chk("wrd_addr", a_log[t0 + 1 + k], 32'h100 + 32'(k));
    chk("wrd_nowr", 32'(nwr(t0, t0 + 6)), 32'd0);

    start(0, 1'b0, 2'd0, 1'b0, 32'h110, 32'h0);
    wait_ack(0, lat, rd);
    chk("sbyte_lat", 32'(lat), 32'd3);
    chk("sbyte_data", rd, 32'hFFFFFF80);

    start(2, 1'b0, 2'd1, 1'b1, 32'h120, 32'h0);
    wait_ack(2, lat, rd);
    chk("uhalf_lat", 32'(lat), 32'd4);
    chk("uhalf_data", rd, 32'h00008001);

    start(2, 1'b1, 2'd2, 1'b0, 32'h140, 32'hA1B2C3D4);
    wait_ack(2, lat, rd);
    chk("wwr_lat", 32'(lat), 32'd5);
    chk("wwr_rdata", rd, 32'h0);
    chk("wwr_cnt", 32'(nwr(t0 + 1, t0 + 4)), 32'd4);
    chk("wwr_ram", {ram[10'h143], ram[10'h142], ram[10'h141], ram[10'h140]}, 32'hA1B2C3D4);

    start(0, 1'b1, 2'd0, 1'b0, 32'h150, 32'h5A);
    wait_ack(0, lat, rd);
    chk("bwr_lat", 32'(lat), 32'd2);
    chk("bwr_ram", 32'(ram[10'h150]), 32'h5A);

    start(1, 1'b1, 2'd0, 1'b0, 32'h30000, 32'h41);
    io_buffer_full = 1'b1;
    for (int i = 0; i < 4; i++) tick;
    io_buffer_full = 1'b0;
    wait_ack(1, lat, rd);
    chk("io_stall", 32'(nwr(t0, t0 + 3)), 32'd0);
    chk("io_wr", 32'(wr_log[t0 + 4]), 32'd1);
    chk("io_addr", a_log[t0 + 4], 32'h30000);
    chk("io_dout", 32'(d_log[t0 + 4]), 32'h41);
    chk("io_lat", 32'(lat), 32'd5);

    start(0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
    for (int i = 0; i < 3; i++) tick;
    flush = 1'b1;
    ch_req[0] = 1'b0;
    tick;
    flush = 1'b0;
    tick;
    chk("fl_idle", 32'(b_s), 32'd0);
    nack = 0;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (ack_s[0]) nack++;
    end
    chk("fl_noack", 32'(nack), 32'd0);

    start(2, 1'b1, 2'd2, 1'b0, 32'h160, 32'h11223344);
    tick;
    tick;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    wait_ack(2, lat, rd);
    chk("flst_lat", 32'(lat), 32'd5);
    chk("flst_cnt", 32'(nwr(t0 + 1, t0 + 4)), 32'd4);

    start(1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
    tick;
    tick;
    rdy_in = 1'b0;
    tick;
    tick;
    rdy_in = 1'b1;
    wait_ack(1, lat, rd);
    chk("rdy_lat", 32'(lat), 32'd8);
    chk("rdy_data", rd, 32'h12345678);
    chk("rdy_nowr", 32'(nwr(t0, t0 + 8)), 32'd0);

    do_reset;
    keep = 1'b1;
    ch_we = '0;
    ch_size = '0;
    ch_addr = {3{32'h110}};
    ch_req = 3'b111;
    nr = 0;
    nf = 0;
    for (int i = 0; i < 4; i++) rr_ids[i] = -1;
    for (int i = 0; i < 3; i++) fp_ids[i] = -1;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (ack_s != 0 && nr < 4) begin rr_ids[nr] = oh(ack_s); nr++; end
      if (fack_s != 0 && nf < 3) begin fp_ids[nf] = oh(fack_s); nf++; end
    end
    ch_req = '0;
    keep = 1'b0;
    chk("rr_0", 32'(rr_ids[0]), 32'd0);
    chk("rr_1", 32'(rr_ids[1]), 32'd1);
    chk("rr_2", 32'(rr_ids[2]), 32'd2);
    chk("rr_3", 32'(rr_ids[3]), 32'd0);
    for (int i = 0; i < 3; i++) chk("fp", 32'(fp_ids[i]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
